// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester side and the TX FIFO write side of the UART transmit
// arbiter into one interface.
//   Req       : per-requester "word presented"
//   Req_Data  : packed words, requester i at [i*DATA_BITS +: DATA_BITS]
//   Req_Last  : per-requester "presented word ends the burst"
//   FIFO_Full : TX FIFO cannot accept a write this cycle
//   Grant     : registered one-hot owner (zero when idle)
//   Ack       : per-requester "your word is written this cycle"
//   Wr_En     : TX FIFO write strobe
//   Wr_Data   : word written to the TX FIFO
//   Cur_Id    : index of the current owner (zero when idle)
//   Busy      : an owner holds the FIFO write port
// Modports: master = requesters/FIFO side, slave = arbiter.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           Req;
    logic [NUM_REQ*DATA_BITS-1:0] Req_Data;
    logic [NUM_REQ-1:0]           Req_Last;
    logic                         FIFO_Full;
    logic [NUM_REQ-1:0]           Grant;
    logic [NUM_REQ-1:0]           Ack;
    logic                         Wr_En;
    logic [DATA_BITS-1:0]         Wr_Data;
    logic [ID_W-1:0]              Cur_Id;
    logic                         Busy;

    modport master (
        output Req, Req_Data, Req_Last, FIFO_Full,
        input  Grant, Ack, Wr_En, Wr_Data, Cur_Id, Busy
    );

    modport slave (
        input  Req, Req_Data, Req_Last, FIFO_Full,
        output Grant, Ack, Wr_En, Wr_Data, Cur_Id, Busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ requesters share the write port of a
// UART TX FIFO. An owner keeps the port for a burst of up to MAX_BURST words,
// ending early on Req_Last or when it withdraws its request. Exactly one idle
// cycle separates consecutive bursts.
// Ports:
//   SysClk : clock, rising edge
//   Rst    : asynchronous active-high reset
//   bus    : uart_tx_arbiter_if slave modport (request/write signals)
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 4
) (
    input logic               SysClk,
    input logic               Rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     cur_id_q, cur_id_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                wr_en;
    logic [CNT_W-1:0]    cnt_inc;

    // First requester with Req high, searching upward from ptr with wrap.
    // Iterating from the farthest offset down lets the nearest one win.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [ID_W-1:0]    ptr);
        logic [ID_W-1:0] pick;
        int              idx;
        pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) pick = ID_W'(idx);
        end
        return pick;
    endfunction

    // Write path is combinational from the registered owner and live inputs.
    assign wr_en       = (state_q == OWN) && bus.Req[cur_id_q] && !bus.FIFO_Full;
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign bus.Wr_En   = wr_en;
    assign bus.Ack     = wr_en ? grant_q : '0;
    assign bus.Wr_Data = (state_q == OWN) ? bus.Req_Data[int'(cur_id_q)*DATA_BITS +: DATA_BITS]
                                          : '0;
    assign bus.Grant   = grant_q;
    assign bus.Cur_Id  = cur_id_q;
    assign bus.Busy    = (state_q == OWN);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.Req) begin
                    cur_id_d = rr_pick(bus.Req, ptr_q);
                    grant_d  = {{(NUM_REQ-1){1'b0}}, 1'b1} << cur_id_d;
                    cnt_d    = '0;
                    state_d  = OWN;
                end
            end
            OWN: begin
                if (wr_en) cnt_d = cnt_inc;
                // Last word and burst limit coinciding still release only once.
                if (!bus.Req[cur_id_q] ||
                    (wr_en && (bus.Req_Last[cur_id_q] || cnt_inc == CNT_W'(MAX_BURST)))) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    cur_id_d = '0;
                    cnt_d    = '0;
                    ptr_d    = (cur_id_q == ID_W'(NUM_REQ - 1)) ? '0 : cur_id_q + ID_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SysClk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cur_id_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_id_q <= cur_id_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8, MAX_BURST=4).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) ifc ();

    uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .MAX_BURST(4)) dut (
        .SysClk (clk),
        .Rst    (rst),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifc.Req = '0; ifc.Req_Data = '0; ifc.Req_Last = '0; ifc.FIFO_Full = 1'b0;
        rst = 1'b1;
        tick(); tick();
        #1;
        total++; if (ifc.Grant !== 4'b0000) begin bad++; $display("FAIL rst_grant got=%b want=0000", ifc.Grant); end
        total++; if (ifc.Ack !== 4'b0000) begin bad++; $display("FAIL rst_ack got=%b want=0000", ifc.Ack); end
        total++; if ({ifc.Wr_En, ifc.Busy, ifc.Cur_Id} !== 4'b0000) begin bad++; $display("FAIL rst_ctrl got=%b want=0000", {ifc.Wr_En, ifc.Busy, ifc.Cur_Id}); end
        total++; if (ifc.Wr_Data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", ifc.Wr_Data); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        ifc.Req_Data = {8'h23, 8'h22, 8'h21, 8'h20};
        ifc.Req = 4'b1010;
        #1;
        total++; if (ifc.Grant !== 4'b0000) begin bad++; $display("FAIL basic_pre got=%b want=0000", ifc.Grant); end
        tick();
        total++; if (ifc.Grant !== 4'b0010) begin bad++; $display("FAIL basic_grant1 got=%b want=0010", ifc.Grant); end
        total++; if (ifc.Cur_Id !== 2'd1 || ifc.Busy !== 1'b1) begin bad++; $display("FAIL basic_id1 got=%0d/%b want=1/1", ifc.Cur_Id, ifc.Busy); end
        total++; if (ifc.Wr_En !== 1'b1 || ifc.Wr_Data !== 8'h21 || ifc.Ack !== 4'b0010) begin bad++; $display("FAIL basic_wr1 got=%b/%h/%b want=1/21/0010", ifc.Wr_En, ifc.Wr_Data, ifc.Ack); end
        ifc.Req_Last = 4'b0010;
        tick();
        total++; if (ifc.Grant !== 4'b0000 || ifc.Busy !== 1'b0 || ifc.Wr_En !== 1'b0) begin bad++; $display("FAIL basic_gap got=%b/%b/%b want=0000/0/0", ifc.Grant, ifc.Busy, ifc.Wr_En); end
        ifc.Req_Last = 4'b0000;
        tick();
        total++; if (ifc.Grant !== 4'b1000 || ifc.Cur_Id !== 2'd3) begin bad++; $display("FAIL basic_grant3 got=%b/%0d want=1000/3", ifc.Grant, ifc.Cur_Id); end
        total++; if (ifc.Wr_Data !== 8'h23 || ifc.Ack !== 4'b1000) begin bad++; $display("FAIL basic_wr3 got=%h/%b want=23/1000", ifc.Wr_Data, ifc.Ack); end
        ifc.Req = 4'b0000;
        #1;
        total++; if (ifc.Wr_En !== 1'b0) begin bad++; $display("FAIL basic_nowr got=%b want=0", ifc.Wr_En); end
        tick();
        total++; if (ifc.Grant !== 4'b0000) begin bad++; $display("FAIL basic_rel3 got=%b want=0000", ifc.Grant); end
        tick();
    endtask

    task automatic test_burst_limit();
        logic [7:0] words [4];
        int nwr;
        words[0] = 8'hBB; words[1] = 8'hAA; words[2] = 8'h55; words[3] = 8'h0F;
        nwr = 0;
        ifc.Req = 4'b0001;
        ifc.Req_Data = {8'h00, 8'h00, 8'h00, 8'hBB};
        tick();
        for (int i = 0; i < 4; i++) begin
            ifc.Req_Data[7:0] = words[i];
            #1;
            if (ifc.Wr_En === 1'b1) nwr++;
            total++; if (ifc.Grant !== 4'b0001 || ifc.Wr_Data !== words[i]) begin bad++; $display("FAIL burst_word%0d got=%b/%h want=0001/%h", i, ifc.Grant, ifc.Wr_Data, words[i]); end
            tick();
        end
        total++; if (nwr !== 4) begin bad++; $display("FAIL burst_count got=%0d want=4", nwr); end
        total++; if (ifc.Grant !== 4'b0000 || ifc.Wr_En !== 1'b0) begin bad++; $display("FAIL burst_release got=%b/%b want=0000/0", ifc.Grant, ifc.Wr_En); end
        ifc.Req_Data[7:0] = 8'h11;
        tick();
        total++; if (ifc.Grant !== 4'b0001 || ifc.Wr_En !== 1'b1 || ifc.Wr_Data !== 8'h11) begin bad++; $display("FAIL burst_regrant got=%b/%b/%h want=0001/1/11", ifc.Grant, ifc.Wr_En, ifc.Wr_Data); end
        ifc.Req_Last = 4'b0001;
        tick();
        ifc.Req = 4'b0000; ifc.Req_Last = 4'b0000;
        tick();
    endtask

    task automatic test_fifo_full();
        int held;
        held = 0;
        ifc.Req_Data = {8'h00, 8'hC2, 8'h00, 8'h00};
        ifc.Req = 4'b0100;
        ifc.FIFO_Full = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            if (ifc.Wr_En === 1'b0 && ifc.Grant === 4'b0100 && ifc.Ack === 4'b0000) held++;
            tick();
        end
        total++; if (held !== 5) begin bad++; $display("FAIL full_hold got=%0d want=5", held); end
        ifc.FIFO_Full = 1'b0;
        #1;
        total++; if (ifc.Wr_En !== 1'b1 || ifc.Wr_Data !== 8'hC2 || ifc.Ack !== 4'b0100) begin bad++; $display("FAIL full_resume got=%b/%h/%b want=1/c2/0100", ifc.Wr_En, ifc.Wr_Data, ifc.Ack); end
        ifc.Req_Last = 4'b0100;
        tick();
        ifc.Req = 4'b0000; ifc.Req_Last = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        int order [5];
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.Req_Data = {8'h33, 8'h32, 8'h31, 8'h30};
        ifc.Req = 4'b1111;
        ifc.Req_Last = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (ifc.Grant !== (4'b0001 << order[i]) || ifc.Wr_Data !== (8'h30 + 8'(order[i]))) begin bad++; $display("FAIL rr_grant%0d got=%b/%h want=%b/%h", i, ifc.Grant, ifc.Wr_Data, 4'b0001 << order[i], 8'h30 + 8'(order[i])); end
            tick();
            total++; if (ifc.Grant !== 4'b0000) begin bad++; $display("FAIL rr_gap%0d got=%b want=0000", i, ifc.Grant); end
        end
        ifc.Req = 4'b0000; ifc.Req_Last = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        ifc.Req_Data = {8'hD1, 8'h00, 8'h00, 8'hE0};
        ifc.Req = 4'b1000;
        tick();
        ifc.Req_Data[31:24] = 8'hD2;
        tick();
        total++; if (ifc.Grant !== 4'b1000 || ifc.Wr_Data !== 8'hD2 || ifc.Wr_En !== 1'b1) begin bad++; $display("FAIL mid_second got=%b/%h/%b want=1000/d2/1", ifc.Grant, ifc.Wr_Data, ifc.Wr_En); end
        rst = 1'b1;
        #1;
        total++; if ({ifc.Grant, ifc.Ack, ifc.Wr_En, ifc.Busy, ifc.Cur_Id} !== 12'h000 || ifc.Wr_Data !== 8'h00) begin bad++; $display("FAIL mid_rst got=%b/%b/%b/%b/%0d/%h want=all 0", ifc.Grant, ifc.Ack, ifc.Wr_En, ifc.Busy, ifc.Cur_Id, ifc.Wr_Data); end
        ifc.Req = 4'b1001;
        tick();
        total++; if (ifc.Grant !== 4'b0000 || ifc.Wr_En !== 1'b0) begin bad++; $display("FAIL mid_hold got=%b/%b want=0000/0", ifc.Grant, ifc.Wr_En); end
        rst = 1'b0;
        tick();
        total++; if (ifc.Grant !== 4'b0001 || ifc.Wr_Data !== 8'hE0) begin bad++; $display("FAIL mid_after got=%b/%h want=0001/e0", ifc.Grant, ifc.Wr_Data); end
        ifc.Req = 4'b0000;
        tick();
        tick();
    endtask

    task automatic test_drop();
        ifc.Req_Data = {8'h00, 8'hF2, 8'hF1, 8'hF0};
        ifc.Req = 4'b0010;
        tick();
        ifc.Req = 4'b0000;
        #1;
        total++; if (ifc.Grant !== 4'b0010 || ifc.Wr_En !== 1'b0 || ifc.Ack !== 4'b0000) begin bad++; $display("FAIL drop_nowr got=%b/%b/%b want=0010/0/0000", ifc.Grant, ifc.Wr_En, ifc.Ack); end
        tick();
        total++; if (ifc.Grant !== 4'b0000 || ifc.Busy !== 1'b0) begin bad++; $display("FAIL drop_rel got=%b/%b want=0000/0", ifc.Grant, ifc.Busy); end
        ifc.Req = 4'b0111;
        tick();
        total++; if (ifc.Grant !== 4'b0100 || ifc.Cur_Id !== 2'd2) begin bad++; $display("FAIL drop_ptr got=%b/%0d want=0100/2", ifc.Grant, ifc.Cur_Id); end
        total++; if (ifc.Ack !== 4'b0100 || ifc.Wr_Data !== 8'hF2) begin bad++; $display("FAIL drop_others got=%b/%h want=0100/f2", ifc.Ack, ifc.Wr_Data); end
        ifc.Req = 4'b0000;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_burst_limit();
        test_fifo_full();
        test_round_robin();
        test_reset_mid_burst();
        test_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
